// File: rtl/multicycle_control_fsm_if.sv
// Bus between the multicycle controller and its datapath: decoded IR fields and
// status flags in, select lines, write strobes and debug/status out.
interface multicycle_control_fsm_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    logic        adr_src;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  imm_src;
    logic [2:0]  alu_control;
    logic [3:0]  state;
    logic        instr_done;
    logic        illegal;
    logic [31:0] instr_count;

    // Controller side.
    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_write, ir_write, mem_write, reg_write,
        output adr_src, result_src, alu_src_a, alu_src_b, imm_src, alu_control,
        output state, instr_done, illegal, instr_count
    );

    // Datapath side.
    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_write, ir_write, mem_write, reg_write,
        input  adr_src, result_src, alu_src_a, alu_src_b, imm_src, alu_control,
        input  state, instr_done, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multicycle RV32 subset (lw, sw, R-type, I-type ALU, beq, jal)
// with memory-ready stalls, an illegal-opcode trap and a retired-instruction counter.
module multicycle_control_fsm (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_control_fsm_if.master       bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0]  state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic        pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw, done_raw;
    logic        adr_src, use_funct;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  alu_fixed, alu_funct;
    logic        instr_done;

    // Next-state logic; mem_ready only matters in FETCH, MEMREAD and MEMWRITE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (rst) state_d = S_FETCH;
    end

    // Per-state datapath selects and ungated write strobes.
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_fixed     = ALU_ADD;
        use_funct     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = bus.mem_ready;
                pc_write_raw = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = bus.mem_ready;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                use_funct = 1'b1;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                use_funct = 1'b1;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_fixed    = ALU_SUB;
                pc_write_raw = bus.zero;
                done_raw     = 1'b1;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // funct3/funct7 decode; subtract only for register-register ops.
    always_comb begin
        alu_funct = ALU_ADD;
        unique case (bus.funct3)
            3'b000:  alu_funct = (state_q == S_EXECR && bus.funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        bus.imm_src = 2'b00;
        unique case (bus.op)
            OP_SW:   bus.imm_src = 2'b01;
            OP_BEQ:  bus.imm_src = 2'b10;
            OP_JAL:  bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

    assign instr_done = done_raw & ~rst;

    always_comb begin
        instr_count_d = instr_count_q + {31'd0, instr_done};
        if (rst) instr_count_d = '0;
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        instr_count_q <= instr_count_d;
    end

    assign bus.pc_write    = pc_write_raw  & ~rst;
    assign bus.ir_write    = ir_write_raw  & ~rst;
    assign bus.mem_write   = mem_write_raw & ~rst;
    assign bus.reg_write   = reg_write_raw & ~rst;
    assign bus.instr_done  = instr_done;
    assign bus.adr_src     = adr_src;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = use_funct ? alu_funct : alu_fixed;
    assign bus.state       = state_q;
    assign bus.illegal     = (state_q == S_TRAP);
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through
// the FSM with hand-computed per-cycle expectations.
module tb_multicycle_control_fsm;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [4:0] strobes();
        return {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.instr_done};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.op = 7'd0;
        bus.funct3 = 3'd0;
        bus.funct7_5 = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state, strobes suppressed while rst is high.
        tick(); tick();
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_count", bus.instr_count, 0);
        chk("rst_strobes", strobes(), 0);

        // R-type sub.
        rst = 1'b0; bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b1;
        #1;
        chk("r_fetch_strobes", strobes(), 5'b11000);
        chk("r_fetch_sel", {bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src}, 7'b0_00_10_10);
        tick(); #1;
        chk("r_decode", {bus.state, bus.alu_src_a, bus.alu_src_b}, {4'd1, 2'b01, 2'b01});
        tick(); #1;
        chk("r_execr", {bus.state, bus.alu_control, bus.alu_src_a, bus.alu_src_b}, {4'd6, 3'b001, 2'b10, 2'b00});
        tick(); #1;
        chk("r_aluwb", {bus.state, strobes(), bus.result_src}, {4'd8, 5'b00011, 2'b00});
        tick(); #1;
        chk("r_retired", {bus.state, bus.instr_count}, {4'd0, 32'd1});

        // lw with two wait cycles in FETCH and in MEMREAD.
        bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0; bus.mem_ready = 1'b0;
        #1;
        chk("lw_fetch_wait1", {bus.state, strobes()}, {4'd0, 5'b0});
        tick(); #1;
        chk("lw_fetch_wait2", {bus.state, strobes(), bus.alu_src_b, bus.result_src}, {4'd0, 5'b0, 2'b10, 2'b10});
        tick(); bus.mem_ready = 1'b1; #1;
        chk("lw_fetch_go", {bus.state, strobes()}, {4'd0, 5'b11000});
        tick(); bus.mem_ready = 1'b0; #1;
        chk("lw_decode", {bus.state, bus.imm_src, strobes()}, {4'd1, 2'b00, 5'b0});
        tick(); #1;
        chk("lw_memadr", {bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_control}, {4'd2, 2'b10, 2'b01, 3'b000});
        tick(); #1;
        chk("lw_memread1", {bus.state, bus.adr_src, strobes()}, {4'd3, 1'b1, 5'b0});
        tick(); #1;
        chk("lw_memread2", {bus.state, bus.adr_src}, {4'd3, 1'b1});
        tick(); bus.mem_ready = 1'b1; #1;
        chk("lw_memread3", {bus.state, strobes()}, {4'd3, 5'b0});
        tick(); bus.mem_ready = 1'b0; #1;
        chk("lw_memwb", {bus.state, strobes(), bus.result_src}, {4'd4, 5'b00011, 2'b01});
        tick(); #1;
        chk("lw_retired", {bus.state, bus.instr_count}, {4'd0, 32'd2});

        // beq taken then not taken.
        bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        tick(); #1;
        chk("beq1_decode", {bus.state, bus.imm_src}, {4'd1, 2'b10});
        tick(); #1;
        chk("beq1_exec", {bus.state, strobes(), bus.alu_control, bus.alu_src_a, bus.alu_src_b},
            {4'd9, 5'b10001, 3'b001, 2'b10, 2'b00});
        tick(); bus.zero = 1'b0;
        tick(); tick(); #1;
        chk("beq0_exec", {bus.state, strobes()}, {4'd9, 5'b00001});
        tick(); #1;
        chk("beq_count", {bus.state, bus.instr_count}, {4'd0, 32'd4});

        // I-type addi with funct7_5 set must still add.
        bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b1;
        tick(); tick(); #1;
        chk("addi_execi", {bus.state, bus.alu_control, bus.alu_src_b}, {4'd7, 3'b000, 2'b01});
        bus.funct3 = 3'b110; #1;
        chk("ori_execi", bus.alu_control, 3'b011);
        tick(); tick(); #1;
        chk("addi_count", {bus.state, bus.instr_count}, {4'd0, 32'd5});

        // sw completing normally.
        bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0;
        tick(); #1;
        chk("sw_decode", {bus.state, bus.imm_src}, {4'd1, 2'b01});
        tick(); tick(); #1;
        chk("sw_memwrite_done", {bus.state, strobes(), bus.adr_src}, {4'd5, 5'b00101, 1'b1});
        tick(); #1;
        chk("sw_count", {bus.state, bus.instr_count}, {4'd0, 32'd6});

        // sw reset while stalled in MEMWRITE.
        tick(); tick(); tick(); bus.mem_ready = 1'b0; #1;
        chk("swr_wait1", {bus.state, strobes()}, {4'd5, 5'b00100});
        tick(); #1;
        chk("swr_wait2", {bus.state, strobes()}, {4'd5, 5'b00100});
        rst = 1'b1; bus.mem_ready = 1'b1; #1;
        chk("swr_rst_strobes", strobes(), 5'b0);
        tick(); #1;
        chk("swr_after", {bus.state, bus.instr_count, strobes()}, {4'd0, 32'd0, 5'b0});
        rst = 1'b0;

        // Illegal opcode traps until reset.
        bus.op = 7'b1111111; bus.mem_ready = 1'b1;
        tick(); tick(); #1;
        chk("trap_enter", {bus.state, bus.illegal}, {4'd11, 1'b1});
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            tick(); #1;
            chk("trap_hold", {bus.state, bus.illegal, strobes()}, {4'd11, 1'b1, 5'b0});
        end
        rst = 1'b1;
        tick(); #1;
        chk("trap_rst", {bus.state, bus.illegal, bus.instr_count}, {4'd0, 1'b0, 32'd1 - 32'd1});
        rst = 1'b0;

        // Counter wrap on a jal.
        bus.mem_ready = 1'b0;
        force dut.instr_count_d = 32'hFFFF_FFFF;
        tick();
        release dut.instr_count_d;
        #1;
        chk("wrap_preload", bus.instr_count, 32'hFFFF_FFFF);
        tick(); #1;
        chk("wrap_hold", bus.instr_count, 32'hFFFF_FFFF);
        bus.op = 7'b1101111; bus.mem_ready = 1'b1;
        tick(); #1;
        chk("jal_decode", {bus.state, bus.imm_src}, {4'd1, 2'b11});
        tick(); #1;
        chk("jal_exec", {bus.state, bus.alu_control, strobes(), bus.alu_src_a, bus.alu_src_b},
            {4'd10, 3'b000, 5'b10000, 2'b01, 2'b10});
        tick(); #1;
        chk("jal_aluwb", {bus.state, strobes()}, {4'd8, 5'b00011});
        tick(); #1;
        chk("wrap_count", {bus.state, bus.instr_count}, {4'd0, 32'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
